// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Shared types and helpers for the configurable UART receiver.
//   - parity_e        : decoded parity mode (2'b11 on the pins decodes to none)
//   - uart_rx_state_e : receiver frame FSM states
//   - rx_cfg_t        : per-frame configuration captured at start-bit detection
//   - majority3       : 2-of-3 vote used for every bit decision
//   - decode_parity   : pin encoding -> parity_e
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int MIN_DATA_BITS = 5;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_ODD  = 2'b01,
        PAR_EVEN = 2'b10
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        WAIT_HIGH
    } uart_rx_state_e;

    typedef struct packed {
        logic [3:0] nbits;
        parity_e    parity;
        logic       two_stop;
    } rx_cfg_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic parity_e decode_parity(input logic [1:0] mode);
        case (mode)
            2'b01:   return PAR_ODD;
            2'b10:   return PAR_EVEN;
            default: return PAR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// ----------------------------------------------------------------------------
// uart_rx_cfg_if
//   Output handshake bundle between the receiver (master) and the
//   register/FIFO layer that consumes received words (slave).
//   rx_data     : received word, right-justified, unused MSBs zero
//   rx_valid    : rx_data and the error flags are held and valid
//   rx_ready    : consumer accept; a transfer is rx_valid && rx_ready
//   parity_err  : parity mismatch for the held word
//   frame_err   : a stop bit sampled low for the held word
//   overrun_err : a frame was dropped while rx_valid was held
//   break_det   : one-clk break pulse (tied 0 unless break detection is built)
// ----------------------------------------------------------------------------
interface uart_rx_cfg_if #(
    parameter int MAX_DATA_BITS = 9
);
    logic [MAX_DATA_BITS-1:0] rx_data;
    logic                     rx_valid;
    logic                     rx_ready;
    logic                     parity_err;
    logic                     frame_err;
    logic                     overrun_err;
    logic                     break_det;

    modport master (
        output rx_data, rx_valid, parity_err, frame_err, overrun_err, break_det,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, parity_err, frame_err, overrun_err, break_det,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_sync.sv
// ----------------------------------------------------------------------------
// uart_rx_sync
//   SYNC_STAGES-deep flop chain bringing an asynchronous, idle-high line into
//   the clk domain. Flops reset to 1 so a reset never looks like a start bit.
//   clk   : system clock
//   reset : synchronous, active-high
//   d     : asynchronous input
//   q     : synchronised output
// ----------------------------------------------------------------------------
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, regardless of block order.
    always_ff @(posedge clk) begin
        if (reset) sync_q <= '1;
        else       sync_q <= sync_d;
    end

    assign q = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/uart_rx_cfg.sv
// ----------------------------------------------------------------------------
// uart_rx_cfg
//   Runtime-configurable UART receiver: 5..MAX_DATA_BITS data bits, none/odd/
//   even parity, 1 or 2 stop bits. 3-sample majority vote per bit, start-glitch
//   rejection, valid/ready output with sticky overrun, and completion at the
//   middle of the final stop bit so the next start edge is never missed.
//   Optional break detection is built when UART_RX_BREAK_DETECT_EN is defined.
//
//   clk         : system clock
//   reset       : synchronous, active-high
//   tick_16x    : one-clk oversample strobe; all bit timing advances on it
//   rx_pin      : asynchronous serial line, idle high
//   data_bits   : data bits per frame (clamped to 5..MAX_DATA_BITS)
//   parity_mode : 00 none, 01 odd, 10 even, 11 none
//   stop_bits   : 0 one stop bit, 1 two stop bits
//   rx_bus      : output handshake (uart_rx_cfg_if.master)
// ----------------------------------------------------------------------------
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int MAX_DATA_BITS = 9,
    parameter int OVS_FACTOR    = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick_16x,
    input  logic                 rx_pin,
    input  logic [3:0]           data_bits,
    input  logic [1:0]           parity_mode,
    input  logic                 stop_bits,
    uart_rx_cfg_if.master        rx_bus
);
    localparam int OS_W = $clog2(OVS_FACTOR);
    typedef logic [OS_W-1:0] os_t;

    // The vote samples straddle the bit centre; the decision lands on the last one.
    localparam os_t OS_S0   = os_t'(OVS_FACTOR / 2 - 1);
    localparam os_t OS_S1   = os_t'(OVS_FACTOR / 2);
    localparam os_t OS_VOTE = os_t'(OVS_FACTOR / 2 + 1);
    localparam os_t OS_LAST = os_t'(OVS_FACTOR - 1);

    if (OVS_FACTOR < 8 || OVS_FACTOR > 32 || (OVS_FACTOR & (OVS_FACTOR - 1)) != 0) begin : g_bad_ovs
        $fatal(1, "uart_rx_cfg: OVS_FACTOR must be a power of 2 in 8..32");
    end
    if (MAX_DATA_BITS < MIN_DATA_BITS || MAX_DATA_BITS > 9) begin : g_bad_width
        $fatal(1, "uart_rx_cfg: MAX_DATA_BITS must be in 5..9");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $fatal(1, "uart_rx_cfg: SYNC_STAGES must be at least 2");
    end

    function automatic logic [3:0] clamp_bits(input logic [3:0] n);
        if (n < 4'(MIN_DATA_BITS)) return 4'(MIN_DATA_BITS);
        if (n > 4'(MAX_DATA_BITS)) return 4'(MAX_DATA_BITS);
        return n;
    endfunction

    logic rx_s;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx_pin),
        .q     (rx_s)
    );

    // Frame state
    uart_rx_state_e           state_q,   state_d;
    os_t                      os_q,      os_d;
    logic [3:0]               bit_idx_q, bit_idx_d;
    logic                     s0_q,      s0_d;
    logic                     s1_q,      s1_d;
    rx_cfg_t                  cfg_q,     cfg_d;
    logic [MAX_DATA_BITS-1:0] data_q,    data_d;
    logic                     par_err_q, par_err_d;
    logic                     stop1_ok_q, stop1_ok_d;

    // Output register
    logic [MAX_DATA_BITS-1:0] rx_data_q,    rx_data_d;
    logic                     rx_valid_q,   rx_valid_d;
    logic                     parity_err_q, parity_err_d;
    logic                     frame_err_q,  frame_err_d;
    logic                     overrun_q,    overrun_d;

`ifdef UART_RX_BREAK_DETECT_EN
    // Cleared by any data or parity vote of 1 within the current frame.
    logic                     all_zero_q,   all_zero_d;
    logic                     break_q,      break_d;
`endif

    logic vote;
    logic frame_done;
    logic frame_ferr;
    logic frame_brk;
    logic deliver;

    always_comb begin
        // NOTE: every value driven here gets a default first, so no path can
        // leave it unassigned and infer a latch.
        state_d      = state_q;
        os_d         = os_q;
        bit_idx_d    = bit_idx_q;
        s0_d         = s0_q;
        s1_d         = s1_q;
        cfg_d        = cfg_q;
        data_d       = data_q;
        par_err_d    = par_err_q;
        stop1_ok_d   = stop1_ok_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = overrun_q;
        frame_done   = 1'b0;
        frame_ferr   = 1'b0;
        frame_brk    = 1'b0;
        vote         = majority3(s0_q, s1_q, rx_s);
`ifdef UART_RX_BREAK_DETECT_EN
        all_zero_d   = all_zero_q;
        break_d      = 1'b0;
`endif

        if (tick_16x) begin
            os_d = (os_q == OS_LAST) ? '0 : os_q + 1'b1;
            if (os_q == OS_S0) s0_d = rx_s;
            if (os_q == OS_S1) s1_d = rx_s;

            case (state_q)
                IDLE: begin
                    os_d = '0;
                    if (!rx_s) begin
                        state_d    = START;
                        cfg_d      = '{nbits:    clamp_bits(data_bits),
                                       parity:   decode_parity(parity_mode),
                                       two_stop: stop_bits};
                        data_d     = '0;
                        par_err_d  = 1'b0;
                        stop1_ok_d = 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
                        all_zero_d = 1'b1;
`endif
                    end
                end

                START: begin
                    if (os_q == OS_VOTE && vote) begin
                        // Start bit did not survive the vote: treat as a glitch.
                        state_d = IDLE;
                        os_d    = '0;
                    end else if (os_q == OS_LAST) begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end
                end

                DATA: begin
                    if (os_q == OS_VOTE) begin
                        for (int i = 0; i < MAX_DATA_BITS; i++) begin
                            if (bit_idx_q == 4'(i)) data_d[i] = vote;
                        end
`ifdef UART_RX_BREAK_DETECT_EN
                        all_zero_d = all_zero_q & ~vote;
`endif
                    end
                    if (os_q == OS_LAST) begin
                        if (bit_idx_q == cfg_q.nbits - 4'd1)
                            state_d = (cfg_q.parity != PAR_NONE) ? PARITY : STOP1;
                        else
                            bit_idx_d = bit_idx_q + 4'd1;
                    end
                end

                PARITY: begin
                    if (os_q == OS_VOTE) begin
                        par_err_d = vote ^ (^data_q) ^ (cfg_q.parity == PAR_ODD);
`ifdef UART_RX_BREAK_DETECT_EN
                        all_zero_d = all_zero_q & ~vote;
`endif
                    end
                    if (os_q == OS_LAST) state_d = STOP1;
                end

                STOP1: begin
                    if (os_q == OS_VOTE) begin
                        stop1_ok_d = vote;
                        if (!cfg_q.two_stop) begin
                            frame_done = 1'b1;
                            frame_ferr = ~vote;
`ifdef UART_RX_BREAK_DETECT_EN
                            frame_brk  = all_zero_q & ~vote;
`endif
                        end
                    end
                    if (cfg_q.two_stop && os_q == OS_LAST) state_d = STOP2;
                end

                STOP2: begin
                    if (os_q == OS_VOTE) begin
                        frame_done = 1'b1;
                        frame_ferr = ~stop1_ok_q | ~vote;
`ifdef UART_RX_BREAK_DETECT_EN
                        frame_brk  = all_zero_q & ~stop1_ok_q;
`endif
                    end
                end

                WAIT_HIGH: begin
                    // A low stop bit must not be mistaken for the next start bit.
                    os_d = '0;
                    if (rx_s) state_d = IDLE;
                end

                default: state_d = IDLE;
            endcase

            // Finish at mid-stop-bit so the next start edge is caught promptly.
            if (frame_done) begin
                state_d = frame_ferr ? WAIT_HIGH : IDLE;
                os_d    = '0;
            end
        end

        deliver = frame_done & ~frame_brk;

        if (deliver) begin
            if (!rx_valid_q || rx_bus.rx_ready) begin
                rx_data_d    = data_q;
                parity_err_d = par_err_q;
                frame_err_d  = frame_ferr;
                rx_valid_d   = 1'b1;
                overrun_d    = 1'b0;
            end else begin
                overrun_d    = 1'b1;
            end
        end else if (rx_valid_q && rx_bus.rx_ready) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end

`ifdef UART_RX_BREAK_DETECT_EN
        break_d = frame_done & frame_brk;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            os_q         <= '0;
            bit_idx_q    <= '0;
            s0_q         <= 1'b1;
            s1_q         <= 1'b1;
            cfg_q        <= '{nbits: 4'(MIN_DATA_BITS), parity: PAR_NONE, two_stop: 1'b0};
            data_q       <= '0;
            par_err_q    <= 1'b0;
            stop1_ok_q   <= 1'b1;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            all_zero_q   <= 1'b0;
            break_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            os_q         <= os_d;
            bit_idx_q    <= bit_idx_d;
            s0_q         <= s0_d;
            s1_q         <= s1_d;
            cfg_q        <= cfg_d;
            data_q       <= data_d;
            par_err_q    <= par_err_d;
            stop1_ok_q   <= stop1_ok_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef UART_RX_BREAK_DETECT_EN
            all_zero_q   <= all_zero_d;
            break_q      <= break_d;
`endif
        end
    end

    assign rx_bus.rx_data     = rx_data_q;
    assign rx_bus.rx_valid    = rx_valid_q;
    assign rx_bus.parity_err  = parity_err_q;
    assign rx_bus.frame_err   = frame_err_q;
    assign rx_bus.overrun_err = overrun_q;
`ifdef UART_RX_BREAK_DETECT_EN
    assign rx_bus.break_det   = break_q;
`else
    assign rx_bus.break_det   = 1'b0;
`endif

endmodule
